// File: rtl/fetch_pc_ctrl_if.sv
// fetch_pc_ctrl_if
//   Bundle between the fetch sequencer, the core and the instruction ROM.
//   Port summary:
//     start_i, prog_sel_i   program launch request and program select
//     stall_i               core busy, freeze the PC this cycle
//     br_taken_i, br_back_i, br_off_i   branch resolved by the core
//     inst_i                ROM word at address_o (combinational)
//     address_o             ROM address (current PC)
//     inst_o, exec_o        instruction forwarded to the core, execute strobe
//     done_o, err_o         HALT reached, watchdog expiry
//     icount_o              instructions executed since the last start
//   Modports: master = core/ROM side, slave = fetch_pc_ctrl.
interface fetch_pc_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic [1:0]       prog_sel_i;
  logic             stall_i;
  logic             br_taken_i;
  logic             br_back_i;
  logic [7:0]       br_off_i;
  logic [7:0]       inst_i;
  logic [7:0]       address_o;
  logic [7:0]       inst_o;
  logic             exec_o;
  logic             done_o;
  logic             err_o;
  logic [CNT_W-1:0] icount_o;

  modport master (
    output start_i, prog_sel_i, stall_i, br_taken_i, br_back_i, br_off_i, inst_i,
    input  address_o, inst_o, exec_o, done_o, err_o, icount_o
  );

  modport slave (
    input  start_i, prog_sel_i, stall_i, br_taken_i, br_back_i, br_off_i, inst_i,
    output address_o, inst_o, exec_o, done_o, err_o, icount_o
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl
//   Program counter and fetch sequencer in front of the 8-bit instruction ROM.
//   Launches one of three resident programs, applies relative branches,
//   stops on the HALT opcode and counts executed instructions.
//   Ports:
//     clk_i     clock, rising edge
//     reset_i   synchronous active-high reset
//     bus       fetch_pc_ctrl_if.slave (see interface header for signals)
//   Optional feature: define FETCH_WDOG_EN to enable the instruction-count
//   watchdog (parameter WDOG_LIMIT); without it err_o is tied low.
//
//   state  | meaning
//   IDLE   | after reset, PC held, waiting for start
//   RUN    | fetching, one instruction per non-stalled cycle
//   HALTED | HALT (or watchdog) seen, PC held, done_o set
module fetch_pc_ctrl #(
  parameter logic [7:0] PROG0_BASE = 8'd0,
  parameter logic [7:0] PROG1_BASE = 8'd93,
  parameter logic [7:0] PROG2_BASE = 8'd139,
  parameter logic [7:0] HALT_OPC   = 8'h88,
  parameter int         CNT_W      = 16
`ifdef FETCH_WDOG_EN
  ,
  parameter logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(4000)
`endif
) (
  input  logic            clk_i,
  input  logic            reset_i,
  fetch_pc_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       pc;
  logic [CNT_W-1:0] icount;
  logic             done_q;

  logic             launch;
  logic             run_cycle;
  logic [7:0]       base;
  logic [7:0]       pc_seq;
  logic [7:0]       pc_next;
  logic [CNT_W-1:0] icount_inc;

  always_comb begin
    base = PROG0_BASE;
    case (bus.prog_sel_i)
      2'd0:    base = PROG0_BASE;
      2'd1:    base = PROG1_BASE;
      2'd2:    base = PROG2_BASE;
      default: base = PROG0_BASE;
    endcase
  end

  // A start while RUN is ignored; select 3 is an illegal request.
  assign launch    = bus.start_i && (bus.prog_sel_i != 2'd3) && (state != RUN);
  assign run_cycle = (state == RUN) && !bus.stall_i;

  // Branch distance is relative to the following instruction; modulo-256 wrap.
  assign pc_seq = pc + 8'd1;

  always_comb begin
    pc_next = pc_seq;
    if (bus.br_taken_i) begin
      pc_next = bus.br_back_i ? (pc_seq - bus.br_off_i) : (pc_seq + bus.br_off_i);
    end
  end

  assign icount_inc = (&icount) ? icount : (icount + CNT_W'(1));

`ifdef FETCH_WDOG_EN
  logic err_q;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state  <= IDLE;
      pc     <= 8'd0;
      icount <= '0;
      done_q <= 1'b0;
`ifdef FETCH_WDOG_EN
      err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (launch) begin
            state  <= RUN;
            pc     <= base;
            icount <= '0;
            done_q <= 1'b0;
`ifdef FETCH_WDOG_EN
            err_q  <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (run_cycle) begin
            icount <= icount_inc;
            if (bus.inst_i == HALT_OPC) begin
              state  <= HALTED;
              done_q <= 1'b1;
            end
`ifdef FETCH_WDOG_EN
            // The instruction that brings the count to the limit still executes.
            else if (icount_inc == WDOG_LIMIT) begin
              state  <= HALTED;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
`endif
            else begin
              pc <= pc_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-cycle fetch: the ROM word for address_o is forwarded in the same cycle.
  assign bus.address_o = pc;
  assign bus.exec_o    = run_cycle;
  assign bus.inst_o    = run_cycle ? bus.inst_i : 8'h00;
  assign bus.done_o    = done_q;
  assign bus.icount_o  = icount;
`ifdef FETCH_WDOG_EN
  assign bus.err_o     = err_q;
`else
  assign bus.err_o     = 1'b0;
`endif

endmodule
